// File: rtl/core_sequencer.sv
// Multi-cycle fetch/execute sequencer for the single-issue RV32 core.
// Owns the PC, fetches over a req/ack handshake and gates the register-file write into WB.
module core_sequencer #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter logic [31:0] PC_STEP      = 32'd4,
  parameter int unsigned IMEM_TIMEOUT = 32'd15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic [31:0] last_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        ctrl_rf_w,
  output logic        rf_we,
  output logic [31:0] pc,
  output logic [31:0] retired,
  output logic        halted,
  output logic        err
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_WB    = 3'd3,
    ST_HALT  = 3'd4,
    ST_ERR   = 3'd5
  } state_t;

  state_t      state_r;
  state_t      state_s;
  logic [31:0] pc_r;
  logic [31:0] instr_r;
  logic [31:0] retired_r;
  logic [31:0] tmo_cnt_r;
  logic [31:0] tmo_next_s;
  logic        tmo_hit_s;

  // An ack arriving in the expiry cycle wins because ack is tested first in FETCH.
  assign tmo_next_s = tmo_cnt_r + 32'd1;
  assign tmo_hit_s  = (IMEM_TIMEOUT != 32'd0) && (tmo_next_s == IMEM_TIMEOUT);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; HALT and ERR are absorbing, stray encodings fall back to IDLE.
  always_comb begin
    state_s = ST_IDLE;
    case (state_r)
      ST_IDLE: begin
        if (run) state_s = ST_FETCH;
        else     state_s = ST_IDLE;
      end
      ST_FETCH: begin
        if (imem_ack)       state_s = ST_EXEC;
        else if (tmo_hit_s) state_s = ST_ERR;
        else                state_s = ST_FETCH;
      end
      ST_EXEC: state_s = ST_WB;
      ST_WB: begin
        if (pc_r == last_pc) state_s = ST_HALT;
        else if (run)        state_s = ST_FETCH;
        else                 state_s = ST_IDLE;
      end
      ST_HALT: state_s = ST_HALT;
      ST_ERR:  state_s = ST_ERR;
      default: state_s = ST_IDLE;
    endcase
  end

  // Datapath: instruction latch, timeout counter, PC advance and retire count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r      <= RESET_PC;
      instr_r   <= 32'h0000_0000;
      retired_r <= 32'h0000_0000;
      tmo_cnt_r <= 32'h0000_0000;
    end else begin
      case (state_r)
        ST_FETCH: begin
          if (imem_ack) begin
            instr_r   <= imem_rdata;
            tmo_cnt_r <= 32'h0000_0000;
          end else begin
            tmo_cnt_r <= tmo_next_s;
          end
        end
        ST_WB: begin
          retired_r <= retired_r + 32'd1;
          if (pc_r != last_pc) begin
            pc_r <= pc_r + PC_STEP;
          end else begin
            pc_r <= pc_r;
          end
        end
        default: begin
          pc_r <= pc_r;
        end
      endcase
    end
  end

  // Output decode from the registered state; rf_we passes ctrl_rf_w only in WB.
  always_comb begin
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    rf_we       = 1'b0;
    halted      = 1'b0;
    err         = 1'b0;
    case (state_r)
      ST_FETCH: imem_req = 1'b1;
      ST_EXEC:  instr_valid = 1'b1;
      ST_WB: begin
        instr_valid = 1'b1;
        rf_we       = ctrl_rf_w;
      end
      ST_HALT: halted = 1'b1;
      ST_ERR:  err = 1'b1;
      default: imem_req = 1'b0;
    endcase
  end

  assign imem_addr = pc_r;
  assign pc        = pc_r;
  assign instr     = instr_r;
  assign retired   = retired_r;

endmodule

// File: tb/tb_core_sequencer.sv
// Self-checking bench for core_sequencer: cycle-level phase model plus directed scenarios.
module tb_core_sequencer;

  localparam int TMO = 15;
  localparam int P_IDLE = 0, P_FETCH = 1, P_EXEC = 2, P_WB = 3, P_HALT = 4, P_ERR = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic [31:0] last_pc = 32'h0;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        ctrl_rf_w = 1'b0;
  logic        imem_req, instr_valid, rf_we, halted, err;
  logic [31:0] imem_addr, instr, pc, retired;

  core_sequencer #(.RESET_PC(32'h0), .PC_STEP(32'd4), .IMEM_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .last_pc(last_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .instr_valid(instr_valid), .ctrl_rf_w(ctrl_rf_w), .rf_we(rf_we),
    .pc(pc), .retired(retired), .halted(halted), .err(err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Model state: which step of the instruction lifecycle we are in, and architectural values.
  int          m_phase;
  logic [31:0] m_pc, m_instr, m_retired;
  int          m_wait;

  // Memory behaviour knobs.
  int          base_wait = 0;
  logic [31:0] slow_addr = 32'hFFFF_FFFF;
  int          slow_wait = 0;
  bit          stray_ack = 1'b0;
  bit          alt_ctrl = 1'b0;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = P_IDLE; m_pc = 32'h0; m_instr = 32'h0; m_retired = 32'h0; m_wait = 0;
  endtask

  task automatic model_step();
    case (m_phase)
      P_IDLE: if (run) m_phase = P_FETCH;
      P_FETCH: begin
        if (imem_ack) begin
          m_instr = imem_rdata; m_wait = 0; m_phase = P_EXEC;
        end else begin
          m_wait++;
          if (TMO != 0 && m_wait == TMO) m_phase = P_ERR;
        end
      end
      P_EXEC: m_phase = P_WB;
      P_WB: begin
        m_retired = m_retired + 32'd1;
        if (m_pc == last_pc) m_phase = P_HALT;
        else begin
          m_pc = m_pc + 32'd4;
          m_phase = run ? P_FETCH : P_IDLE;
        end
      end
      default: ;
    endcase
  endtask

  task automatic compare_all();
    chk("imem_req", imem_req, m_phase == P_FETCH);
    chk("imem_addr", imem_addr, m_pc);
    chk("pc", pc, m_pc);
    chk("instr", instr, m_instr);
    chk("instr_valid", instr_valid, (m_phase == P_EXEC) || (m_phase == P_WB));
    chk("rf_we", rf_we, (m_phase == P_WB) && ctrl_rf_w);
    chk("retired", retired, m_retired);
    chk("halted", halted, m_phase == P_HALT);
    chk("err", err, m_phase == P_ERR);
  endtask

  task automatic drive_mem();
    int w;
    if (alt_ctrl) ctrl_rf_w = (m_pc[2] == 1'b0);
    w = (m_pc == slow_addr) ? slow_wait : base_wait;
    if (m_phase == P_FETCH) begin
      imem_ack   = (m_wait >= w);
      imem_rdata = imem_ack ? rom(m_pc) : 32'h0BAD_0000;
    end else begin
      imem_ack   = stray_ack;
      imem_rdata = 32'hDEAD_BEEF;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst_n) model_step();
    #2;
    compare_all();
    drive_mem();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    run = 1'b0;
    #1;
    chk("rst_pc", pc, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_req", imem_req, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_valid", instr_valid, 32'h0);
    chk("rst_retired", retired, 32'h0);
    chk("rst_flags", {rf_we, halted, err}, 32'h0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    drive_mem();
  endtask

  task automatic wait_for(input int phase, input logic [31:0] at_pc, input int budget, input string name);
    int n = 0;
    while (!(m_phase == phase && m_pc == at_pc) && n < budget) begin
      cycle();
      n++;
    end
    chk(name, (m_phase == phase && m_pc == at_pc), 32'd1);
  endtask

  initial begin
    int pulses, nchg, last_chg, fetch8;
    logic [31:0] prev;

    // Zero-wait ROM, run to last_pc=0xC.
    ctrl_rf_w = 1'b1; last_pc = 32'h0C;
    do_reset();
    run = 1'b1;
    pulses = 0; nchg = 0; last_chg = 0; prev = pc;
    for (int c = 1; c <= 20; c++) begin
      cycle();
      if (rf_we) pulses++;
      if (pc != prev) begin
        nchg++;
        chk("pc_seq", pc, 32'd4 * nchg);
        if (nchg > 1) chk("pc_gap", c - last_chg, 32'd3);
        last_chg = c;
        prev = pc;
      end
    end
    chk("t1_pulses", pulses, 32'd4);
    chk("t1_halted", halted, 32'd1);
    chk("t1_retired", retired, 32'd4);
    chk("t1_pc", pc, 32'h0C);
    chk("t1_req", imem_req, 32'd0);

    // Three wait cycles per fetch: one retire every 6 cycles.
    base_wait = 3; last_pc = 32'h08;
    do_reset();
    run = 1'b1;
    nchg = 0; last_chg = 0; prev = retired;
    for (int c = 1; c <= 40; c++) begin
      cycle();
      if (retired != prev) begin
        nchg++;
        if (nchg > 1) chk("ret_gap", c - last_chg, 32'd6);
        last_chg = c;
        prev = retired;
      end
    end
    chk("t2_retired", retired, 32'd3);
    chk("t2_halted", halted, 32'd1);

    // Fetch at 0x8 never acknowledged: timeout to ERR.
    base_wait = 0; slow_addr = 32'h08; slow_wait = 1000; last_pc = 32'h40;
    do_reset();
    run = 1'b1;
    fetch8 = 0;
    for (int c = 1; c <= 60; c++) begin
      cycle();
      if (imem_req && imem_addr == 32'h08) fetch8++;
    end
    chk("t3_err", err, 32'd1);
    chk("t3_pc", pc, 32'h08);
    chk("t3_req", imem_req, 32'd0);
    chk("t3_fetch_cycles", fetch8, 32'd15);
    chk("t3_retired", retired, 32'd2);

    // Ack on the 15th cycle wins over the timeout.
    slow_wait = 14; last_pc = 32'h0C;
    do_reset();
    run = 1'b1;
    fetch8 = 0;
    for (int c = 1; c <= 60; c++) begin
      cycle();
      if (imem_req && imem_addr == 32'h08) fetch8++;
    end
    chk("t3b_err", err, 32'd0);
    chk("t3b_halted", halted, 32'd1);
    chk("t3b_retired", retired, 32'd4);
    chk("t3b_fetch_cycles", fetch8, 32'd15);

    // Alternating ctrl_rf_w with stray acks outside FETCH.
    slow_addr = 32'hFFFF_FFFF; alt_ctrl = 1'b1; stray_ack = 1'b1;
    do_reset();
    run = 1'b1;
    pulses = 0;
    for (int c = 1; c <= 20; c++) begin
      cycle();
      if (rf_we) pulses++;
    end
    chk("t4_pulses", pulses, 32'd2);
    chk("t4_instr", instr, 32'hC0DE_000C);
    alt_ctrl = 1'b0; stray_ack = 1'b0; ctrl_rf_w = 1'b1;

    // Drop run during EXEC of pc=0x4, then resume.
    last_pc = 32'h100;
    do_reset();
    run = 1'b1;
    wait_for(P_EXEC, 32'h04, 20, "t5_reach_exec");
    run = 1'b0;
    repeat (5) cycle();
    chk("t5_retired", retired, 32'd2);
    chk("t5_pc", pc, 32'h08);
    chk("t5_req", imem_req, 32'd0);
    chk("t5_valid", instr_valid, 32'd0);
    run = 1'b1;
    cycle();
    chk("t5_resume_req", imem_req, 32'd1);
    chk("t5_resume_addr", imem_addr, 32'h08);

    // Asynchronous reset mid-FETCH at pc=0x10.
    wait_for(P_FETCH, 32'h10, 30, "t6_reach_fetch");
    chk("t6_pre_req", imem_req, 32'd1);
    do_reset();
    run = 1'b1;
    cycle();
    chk("t6_req", imem_req, 32'd1);
    chk("t6_addr", imem_addr, 32'h0);
    chk("t6_retired", retired, 32'd0);
    repeat (4) cycle();
    chk("t6_retired_after", retired, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
